// File: rtl/mdio_pkg.sv
// Purpose: shared constants, state encoding and widths for the MDIO PHY responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdio_pkg;

    // Clause-22 opcodes as they appear on the wire, first bit in the MSB
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    // Field and counter widths
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int PRE_W    = 6;
    localparam int BIT_W    = 4;
    localparam int NUM_REGS = 32;

    // Preamble count saturates here; a start bit is accepted only at this count
    localparam logic [PRE_W-1:0] PRE_MAX   = 6'd32;
    // Last bit index of the 5-bit address fields and the 16-bit data field
    localparam logic [BIT_W-1:0] ADDR_LAST = 4'd4;
    localparam logic [BIT_W-1:0] DATA_LAST = 4'd15;

    // Register indices with special behaviour
    localparam logic [ADDR_W-1:0] REG_BMCR = 5'd0;
    localparam logic [ADDR_W-1:0] REG_BMSR = 5'd1;
    localparam logic [ADDR_W-1:0] REG_ID1  = 5'd2;
    localparam logic [ADDR_W-1:0] REG_ID2  = 5'd3;

    // Fixed status word; bit 2 is replaced by the live link status
    localparam logic [DATA_W-1:0] BMSR_BASE = 16'h7809;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ST2,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA
    } mdio_state_e;

    // Registers 1..3 are read-only; writes to them only produce the strobe
    function automatic logic is_ro_reg(input logic [ADDR_W-1:0] a);
        return (a == REG_BMSR) || (a == REG_ID1) || (a == REG_ID2);
    endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// Purpose: MDC/MDIO pad bundle between an MDIO master and the PHY-side responder.
// Latency: n/a (wires only).
// Backpressure: none; the master paces every bit with MDC.
interface mdio_phy_responder_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_oe;

    modport master (
        output mdc,
        output mdio_i,
        input  mdio_o,
        input  mdio_oe
    );

    modport slave (
        input  mdc,
        input  mdio_i,
        output mdio_o,
        output mdio_oe
    );
endinterface

// File: rtl/mdio_sync_edge.sv
// Purpose: 2-flop synchronizers for MDC and MDIO plus registered MDC rising-edge detect.
// Latency: mdc_rise pulses 3 sys_clk after the MDC pin rises; mdio_s is delayed to match.
// Backpressure: none; MDC phases must each span at least 4 sys_clk.
module mdio_sync_edge (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic mdc_meta_q;
    logic mdc_sync_q;
    logic mdc_prev_q;
    logic rise_q;
    logic mdio_meta_q;
    logic mdio_sync_q;
    logic mdio_s_q;

    // Synchronize both pins and register the edge so data and strobe stay aligned
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mdc_meta_q  <= 1'b0;
            mdc_sync_q  <= 1'b0;
            mdc_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            mdio_meta_q <= 1'b0;
            mdio_sync_q <= 1'b0;
            mdio_s_q    <= 1'b0;
        end else begin
            mdc_meta_q  <= mdc;
            mdc_sync_q  <= mdc_meta_q;
            mdc_prev_q  <= mdc_sync_q;
            rise_q      <= mdc_sync_q & ~mdc_prev_q;
            mdio_meta_q <= mdio_i;
            mdio_sync_q <= mdio_meta_q;
            mdio_s_q    <= mdio_sync_q;
        end
    end

    assign mdc_rise = rise_q;
    assign mdio_s   = mdio_s_q;

endmodule

// File: rtl/mdio_phy_responder.sv
// Purpose: Clause-22 MDIO PHY-side responder with a 32 x 16-bit register file.
// Latency: mdio_o/mdio_oe and wr_pulse update 1 sys_clk after the MDC-edge detect (4 after the pin).
// Backpressure: none; the master paces frames with MDC, each frame needs its own 32-bit preamble.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd1,
    parameter logic [DATA_W-1:0] PHY_ID1  = 16'h001C,
    parameter logic [DATA_W-1:0] PHY_ID2  = 16'hC915,
    parameter logic [DATA_W-1:0] REG0_RST = 16'h1140
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    mdio_phy_responder_if.slave     mdio,
    input  logic                    link_up,
    output logic                    wr_pulse,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    frame_err
);

    logic mdc_rise;
    logic mdio_s;

    mdio_sync_edge u_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .mdc      (mdio.mdc),
        .mdio_i   (mdio.mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    mdio_state_e state_q, state_d;

    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] sh_q, sh_d;
    logic [ADDR_W-1:0] regad_q, regad_d;
    logic              is_rd_q, is_rd_d;
    logic              ta0_q, ta0_d;
    logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
    logic              mdio_o_q, mdio_o_d;
    logic              mdio_oe_q, mdio_oe_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic              soft_rst_q;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] in_word;
    logic [DATA_W-1:0] rd_word;

    // Incoming bits accumulate MSB first; the low bits of in_word hold the current field
    assign in_word = {sh_q, mdio_s};

    // Read view of the register file: status and ID registers are synthesized, not stored
    always_comb begin
        rd_word = regs_q[regad_q];
        case (regad_q)
            REG_BMSR: rd_word = {BMSR_BASE[15:3], link_up, BMSR_BASE[1:0]};
            REG_ID1:  rd_word = PHY_ID1;
            REG_ID2:  rd_word = PHY_ID2;
            default:  ;
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one decision per detected MDC rising edge
    always_comb begin
        state_d = state_q;
        if (mdc_rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (!mdio_s && (pre_cnt_q == PRE_MAX)) state_d = ST_ST2;
                end
                ST_ST2: begin
                    state_d = mdio_s ? ST_OP : ST_IDLE;
                end
                ST_OP: begin
                    if (bit_cnt_q[0]) begin
                        state_d = ((in_word[1:0] == OP_RD) || (in_word[1:0] == OP_WR))
                                  ? ST_PHYAD : ST_IDLE;
                    end
                end
                ST_PHYAD: begin
                    if (bit_cnt_q == ADDR_LAST) begin
                        state_d = (in_word[ADDR_W-1:0] == PHY_ADDR) ? ST_REGAD : ST_IDLE;
                    end
                end
                ST_REGAD: begin
                    if (bit_cnt_q == ADDR_LAST) state_d = ST_TA;
                end
                ST_TA: begin
                    if (bit_cnt_q[0]) begin
                        state_d = (is_rd_q || ({ta0_q, mdio_s} == 2'b10)) ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_q == DATA_LAST) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and datapath next values: counters, shifters, pad drive and strobes
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        regad_d     = regad_q;
        is_rd_d     = is_rd_q;
        ta0_d       = ta0_q;
        rd_sh_d     = rd_sh_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        if (mdc_rise) begin
            sh_d      = in_word[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = '0;
                    if (mdio_s) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end else begin
                        // Either a start bit after a full preamble or a broken preamble
                        pre_cnt_d = '0;
                    end
                end
                ST_ST2: begin
                    bit_cnt_d = '0;
                end
                ST_OP: begin
                    if (bit_cnt_q[0]) begin
                        bit_cnt_d   = '0;
                        is_rd_d     = (in_word[1:0] == OP_RD);
                        frame_err_d = (in_word[1:0] != OP_RD) && (in_word[1:0] != OP_WR);
                    end
                end
                ST_PHYAD: begin
                    if (bit_cnt_q == ADDR_LAST) bit_cnt_d = '0;
                end
                ST_REGAD: begin
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        regad_d   = in_word[ADDR_W-1:0];
                    end
                end
                ST_TA: begin
                    if (!bit_cnt_q[0]) begin
                        ta0_d = mdio_s;
                        if (is_rd_q) begin
                            // Snapshot the word now so a later write cannot tear it
                            rd_sh_d   = rd_word;
                            mdio_oe_d = 1'b1;
                            mdio_o_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        if (is_rd_q) begin
                            mdio_o_d = rd_sh_q[DATA_W-1];
                            rd_sh_d  = {rd_sh_q[DATA_W-2:0], 1'b0};
                        end else if ({ta0_q, mdio_s} != 2'b10) begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (is_rd_q) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            mdio_oe_d = 1'b0;
                            mdio_o_d  = 1'b0;
                        end else begin
                            mdio_o_d = rd_sh_q[DATA_W-1];
                            rd_sh_d  = {rd_sh_q[DATA_W-2:0], 1'b0};
                        end
                    end else if (bit_cnt_q == DATA_LAST) begin
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = regad_q;
                        wr_data_d  = in_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; reset also drops the pad drive and discards partial frames
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            regad_q     <= '0;
            is_rd_q     <= 1'b0;
            ta0_q       <= 1'b0;
            rd_sh_q     <= '0;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            regad_q     <= regad_d;
            is_rd_q     <= is_rd_d;
            ta0_q       <= ta0_d;
            rd_sh_q     <= rd_sh_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Register file: commit on the final data edge; BMCR bit 15 triggers a soft reset next cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst || soft_rst_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? REG0_RST : '0;
            end
        end else if (wr_pulse_d && !is_ro_reg(regad_q)) begin
            if (regad_q == REG_BMCR) begin
                regs_q[regad_q] <= {1'b0, in_word[DATA_W-2:0]};
            end else begin
                regs_q[regad_q] <= in_word;
            end
        end
    end

    // Soft-reset request from a BMCR write with the reset bit set
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            soft_rst_q <= 1'b0;
        end else begin
            soft_rst_q <= wr_pulse_d && (regad_q == REG_BMCR) && in_word[DATA_W-1];
        end
    end

    assign mdio.mdio_o  = mdio_o_q;
    assign mdio.mdio_oe = mdio_oe_q;
    assign wr_pulse     = wr_pulse_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Purpose: directed self-checking bench for mdio_phy_responder driven at MDC pin level.
// Latency: master samples MDIO at the end of each MDC high phase (8 sys_clk after the rise).
// Backpressure: none; the bench paces MDC with 8 sys_clk per phase.
module tb_mdio_phy_responder;
    import mdio_pkg::*;

    localparam int H = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        link_up = 1'b1;
    logic        wr_pulse;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    mdio_phy_responder_if bus ();

    mdio_phy_responder dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mdio      (bus),
        .link_up   (link_up),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Event counters observed away from the active edge
    int          wr_cnt = 0;
    int          ferr_cnt = 0;
    int          oe_cycles = 0;
    logic [4:0]  last_addr = '0;
    logic [15:0] last_data = '0;

    always @(negedge sys_clk) begin
        if (bus.mdio_oe === 1'b1) oe_cycles++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (wr_pulse === 1'b1) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
    end

    // Results of the most recent frame
    logic [15:0] r_rd;
    logic        r_ta2_o, r_ta2_oe, r_oe_end, r_oe_pre, r_oe_post;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic bit_cycle(input logic b, output logic so, output logic soe);
        bus.mdc    = 1'b0;
        bus.mdio_i = b;
        repeat (H) @(negedge sys_clk);
        bus.mdc = 1'b1;
        repeat (H) @(negedge sys_clk);
        so  = bus.mdio_o;
        soe = bus.mdio_oe;
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [1:0] ta,
                         input logic [15:0] wd, input int abort_k);
        logic so, soe, rdf;
        rdf = (op == OP_RD);
        r_rd = '0;
        for (int i = 0; i < pre; i++) bit_cycle(1'b1, so, soe);
        bit_cycle(1'b0, so, soe);
        bit_cycle(1'b1, so, soe);
        for (int i = 1; i >= 0; i--) bit_cycle(op[i], so, soe);
        for (int i = 4; i >= 0; i--) bit_cycle(phy[i], so, soe);
        for (int i = 4; i >= 0; i--) bit_cycle(rg[i], so, soe);
        bit_cycle(rdf ? 1'b1 : ta[1], so, soe);
        r_ta2_o  = so;
        r_ta2_oe = soe;
        bit_cycle(rdf ? 1'b1 : ta[0], so, soe);
        r_rd[15] = so;
        for (int k = 0; k < 16; k++) begin
            if (k == abort_k) begin
                bus.mdc    = 1'b0;
                bus.mdio_i = 1'b1;
                repeat (H) @(negedge sys_clk);
                bus.mdc = 1'b1;
                repeat (H) @(negedge sys_clk);
                r_oe_pre = bus.mdio_oe;
                sys_rst  = 1'b1;
                @(negedge sys_clk);
                sys_rst   = 1'b0;
                r_oe_post = bus.mdio_oe;
                return;
            end
            bit_cycle(rdf ? 1'b1 : wd[15-k], so, soe);
            if (k < 15) r_rd[14-k] = so;
            else        r_oe_end   = soe;
        end
    endtask

    task automatic wr_reg(input logic [4:0] rg, input logic [15:0] d);
        frame(32, OP_WR, 5'd1, rg, 2'b10, d, -1);
    endtask

    task automatic rd_reg(input logic [4:0] rg);
        frame(32, OP_RD, 5'd1, rg, 2'b11, 16'h0000, -1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0, o0;
        bus.mdc    = 1'b0;
        bus.mdio_i = 1'b1;

        // Reset state
        repeat (4) @(negedge sys_clk);
        check1("rst_oe", bus.mdio_oe, 1'b0);
        check1("rst_o", bus.mdio_o, 1'b0);
        check1("rst_wr_pulse", wr_pulse, 1'b0);
        check1("rst_frame_err", frame_err, 1'b0);
        check16("rst_wr_addr", {11'b0, wr_addr}, 16'h0000);
        check16("rst_wr_data", wr_data, 16'h0000);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        // Write A5A5 to reg 5
        w0 = wr_cnt; f0 = ferr_cnt;
        wr_reg(5'd5, 16'hA5A5);
        check16("wr5_count", 16'(wr_cnt - w0), 16'd1);
        check16("wr5_addr", {11'b0, last_addr}, 16'd5);
        check16("wr5_data", last_data, 16'hA5A5);
        check16("wr5_no_ferr", 16'(ferr_cnt - f0), 16'd0);
        check1("wr5_pulse_low", wr_pulse, 1'b0);

        // Read reg 5 back
        rd_reg(5'd5);
        check16("rd5_data", r_rd, 16'hA5A5);
        check1("rd5_ta2_oe", r_ta2_oe, 1'b1);
        check1("rd5_ta2_o", r_ta2_o, 1'b0);
        check1("rd5_oe_release", r_oe_end, 1'b0);

        // Status register follows link_up; ID register
        link_up = 1'b1;
        rd_reg(5'd1);
        check16("rd1_link1", r_rd, 16'h780D);
        link_up = 1'b0;
        rd_reg(5'd1);
        check16("rd1_link0", r_rd, 16'h7809);
        link_up = 1'b1;
        rd_reg(5'd2);
        check16("rd2_id1", r_rd, 16'h001C);

        // Frames to another PHY address are ignored silently
        w0 = wr_cnt; f0 = ferr_cnt; o0 = oe_cycles;
        frame(32, OP_RD, 5'd2, 5'd2, 2'b11, 16'h0000, -1);
        frame(32, OP_WR, 5'd2, 5'd5, 2'b10, 16'hFFFF, -1);
        check16("phy2_oe_cycles", 16'(oe_cycles - o0), 16'd0);
        check16("phy2_no_wr", 16'(wr_cnt - w0), 16'd0);
        check16("phy2_no_ferr", 16'(ferr_cnt - f0), 16'd0);
        rd_reg(5'd5);
        check16("phy2_then_rd5", r_rd, 16'hA5A5);

        // 31-bit preamble is not enough
        w0 = wr_cnt;
        frame(31, OP_WR, 5'd1, 5'd5, 2'b10, 16'h1111, -1);
        check16("pre31_no_wr", 16'(wr_cnt - w0), 16'd0);
        rd_reg(5'd5);
        check16("pre31_rd5", r_rd, 16'hA5A5);

        // Write with bad turnaround
        w0 = wr_cnt; f0 = ferr_cnt;
        frame(32, OP_WR, 5'd1, 5'd5, 2'b11, 16'h2222, -1);
        check16("ta11_ferr", 16'(ferr_cnt - f0), 16'd1);
        check16("ta11_no_wr", 16'(wr_cnt - w0), 16'd0);
        rd_reg(5'd5);
        check16("ta11_rd5", r_rd, 16'hA5A5);

        // Illegal opcode
        w0 = wr_cnt; f0 = ferr_cnt;
        frame(32, 2'b11, 5'd1, 5'd5, 2'b10, 16'h3333, -1);
        check16("op11_ferr", 16'(ferr_cnt - f0), 16'd1);
        check16("op11_no_wr", 16'(wr_cnt - w0), 16'd0);

        // Soft reset through BMCR bit 15
        wr_reg(5'd4, 16'h1234);
        rd_reg(5'd4);
        check16("rd4_before", r_rd, 16'h1234);
        wr_reg(5'd0, 16'h8000);
        check16("bmcr_wr_addr", {11'b0, last_addr}, 16'd0);
        check16("bmcr_wr_data", last_data, 16'h8000);
        rd_reg(5'd4);
        check16("rd4_after_srst", r_rd, 16'h0000);
        rd_reg(5'd0);
        check16("rd0_after_srst", r_rd, 16'h1140);
        rd_reg(5'd5);
        check16("rd5_after_srst", r_rd, 16'h0000);

        // Read-only register keeps storage but still strobes
        w0 = wr_cnt;
        wr_reg(5'd2, 16'hDEAD);
        check16("ro_wr_count", 16'(wr_cnt - w0), 16'd1);
        rd_reg(5'd2);
        check16("ro_rd2", r_rd, 16'h001C);

        // Reset while D7 of a read is on the wire
        frame(32, OP_RD, 5'd1, 5'd3, 2'b11, 16'h0000, 7);
        check1("abort_oe_pre", r_oe_pre, 1'b1);
        check1("abort_oe_post", r_oe_post, 1'b0);
        check16("abort_wr_data_rst", wr_data, 16'h0000);
        wr_reg(5'd6, 16'h0F0F);
        rd_reg(5'd6);
        check16("post_rst_rd6", r_rd, 16'h0F0F);
        rd_reg(5'd3);
        check16("post_rst_rd3", r_rd, 16'hC915);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
